// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver FSM state encodings
// and the even-parity helper also used by the transmitter's parity generator.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Receiver FSM encodings, kept as plain constants for legacy tools
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Even parity: the bit that makes the total count of ones even
  function automatic logic evenParity(input logic [UART_DATA_BITS-1:0] i_Data);
    return ^i_Data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side handshake of the UART receiver: holding register, status flags
// and the read strobe. The receiver uses the master view, the host the slave view.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      Data_Read;
  logic [UART_DATA_BITS-1:0] Data_Out;
  logic                      Data_Valid;
  logic                      Parity_Err;
  logic                      Frame_Err;
  logic                      Overrun;
  logic                      RBusy;

  modport master (
    input  Data_Read,
    output Data_Out, Data_Valid, Parity_Err, Frame_Err, Overrun, RBusy
  );

  modport slave (
    output Data_Read,
    input  Data_Out, Data_Valid, Parity_Err, Frame_Err, Overrun, RBusy
  );

endinterface

// File: rtl/uart_rx_bit_timer.sv
// Sample-point generator for the UART receiver. After a restart it pulses
// o_Strobe H=(CLKS_PER_BIT-1)/2 cycles later (mid start bit), then once every
// CLKS_PER_BIT cycles. When H is 0 the first pulse is already one bit later,
// because the restart cycle itself served as the start-bit check.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_Restart,
  output logic o_Strobe
);

  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] BIT_RELOAD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIRST_RELOAD = (HALF == 0) ? BIT_RELOAD : CW'(HALF - 1);

  logic [CW-1:0] r_Count;

  // Down-counter: loaded on restart, strobes at zero and reloads a full bit period
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_Count <= '0;
    end else if (i_Restart) begin
      r_Count <= FIRST_RELOAD;
    end else if (r_Count == '0) begin
      r_Count <= BIT_RELOAD;
    end else begin
      r_Count <= r_Count - CW'(1);
    end
  end

  assign o_Strobe = (r_Count == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 8 data bits LSB first, even parity, stop bit.
// Received bytes land in a holding register with a valid/read handshake,
// parity/frame error flags and a sticky overrun flag.
// Optional: define UART_RX_SYNC_EN to pass Serial_In through a 2-flop
// synchroniser (adds 2 cycles of latency); otherwise the pin feeds the FSM
// directly for same-clock loopback with the transmitter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic     Clk,
  input  logic     Rst,
  input  logic     Serial_In,
  uart_rx_if.master bus
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  logic                      w_Rx;
  logic                      w_Start;
  logic                      w_Strobe;
  logic                      w_LastBit;

  logic [2:0]                r_State;
  logic [3:0]                r_BitCnt;
  logic [UART_DATA_BITS-1:0] r_Shift;
  logic                      r_ParErrPend;
  logic                      r_FrameErrPend;
  logic                      r_CommitPend;
  logic                      r_BusyEnd;

  logic [UART_DATA_BITS-1:0] r_DataOut;
  logic                      r_DataValid;
  logic                      r_ParityErr;
  logic                      r_FrameErr;
  logic                      r_Overrun;
  logic                      r_Busy;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_Sync;

  // Two-flop synchroniser, reset to the idle (high) line level
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_Sync <= 2'b11;
    end else begin
      r_Sync <= {r_Sync[0], Serial_In};
    end
  end

  assign w_Rx = r_Sync[1];
`else
  assign w_Rx = Serial_In;
`endif

  assign w_Start   = (r_State == ST_IDLE) && !w_Rx;
  assign w_LastBit = (r_BitCnt == 4'(UART_FRAME_BITS - 1));

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_Restart (w_Start),
    .o_Strobe  (w_Strobe)
  );

  // Frame FSM: walks the sample points and leaves a one-cycle commit request
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_State        <= ST_IDLE;
      r_BitCnt       <= '0;
      r_Shift        <= '0;
      r_ParErrPend   <= 1'b0;
      r_FrameErrPend <= 1'b0;
      r_CommitPend   <= 1'b0;
      r_BusyEnd      <= 1'b0;
    end else begin
      r_CommitPend <= 1'b0;
      r_BusyEnd    <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (!w_Rx) begin
            r_BitCnt <= '0;
            r_State  <= (HALF == 0) ? ST_DATA : ST_START;
          end
        end
        ST_START: begin
          if (w_Strobe) begin
            if (!w_Rx) begin
              r_State <= ST_DATA;
            end else begin
              r_State   <= ST_IDLE;
              r_BusyEnd <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_Strobe) begin
            r_Shift  <= {w_Rx, r_Shift[UART_DATA_BITS-1:1]};
            r_BitCnt <= r_BitCnt + 4'd1;
            if (r_BitCnt == 4'(UART_DATA_BITS - 1)) begin
              r_State <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (w_Strobe) begin
            r_ParErrPend <= (w_Rx != evenParity(r_Shift));
            r_BitCnt     <= r_BitCnt + 4'd1;
            r_State      <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_Strobe && w_LastBit) begin
            r_FrameErrPend <= !w_Rx;
            r_CommitPend   <= 1'b1;
            r_BitCnt       <= '0;
            r_State        <= w_Rx ? ST_IDLE : ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (w_Rx) begin
            r_State <= ST_IDLE;
          end
        end
        default: begin
          r_State <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register and flags: commit has priority, a read only clears valid/overrun
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_DataOut   <= '0;
      r_DataValid <= 1'b0;
      r_ParityErr <= 1'b0;
      r_FrameErr  <= 1'b0;
      r_Overrun   <= 1'b0;
    end else if (r_CommitPend) begin
      r_DataOut   <= r_Shift;
      r_ParityErr <= r_ParErrPend;
      r_FrameErr  <= r_FrameErrPend;
      r_DataValid <= 1'b1;
      if (r_DataValid) begin
        r_Overrun <= !bus.Data_Read;
      end
    end else if (bus.Data_Read && r_DataValid) begin
      r_DataValid <= 1'b0;
      r_Overrun   <= 1'b0;
    end
  end

  // Busy rises on start detection and falls one cycle after the FSM is done with the frame
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_Busy <= 1'b0;
    end else if (w_Start) begin
      r_Busy <= 1'b1;
    end else if (r_CommitPend || r_BusyEnd) begin
      r_Busy <= 1'b0;
    end
  end

  assign bus.Data_Out   = r_DataOut;
  assign bus.Data_Valid = r_DataValid;
  assign bus.Parity_Err = r_ParityErr;
  assign bus.Frame_Err  = r_FrameErr;
  assign bus.Overrun    = r_Overrun;
  assign bus.RBusy      = r_Busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clock per bit (transmitter
// loopback timing) and one at 16 clocks per bit. Frames are driven on the
// negative edge, outputs are checked on the negative edge.
module tb_uart_rx;
  import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic Clk  = 1'b0;
  logic Rst  = 1'b0;
  logic rx1  = 1'b1;
  logic rx16 = 1'b1;

  int nCompared   = 0;
  int nMismatched = 0;

  uart_rx_if if1 ();
  uart_rx_if if16 ();

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .Clk       (Clk),
    .Rst       (Rst),
    .Serial_In (rx1),
    .bus       (if1)
  );

  uart_rx #(.CLKS_PER_BIT(16)) dut16 (
    .Clk       (Clk),
    .Rst       (Rst),
    .Serial_In (rx16),
    .bus       (if16)
  );

  // Free-running system clock, 10 time units per cycle
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compares every host-visible output of one instance against expected values
  task automatic checkState(input int sel, input string tag, input logic [7:0] eData,
                            input logic eValid, input logic ePerr, input logic eFerr,
                            input logic eOvr, input logic eBusy);
    logic [7:0] d;
    logic v, p, f, o, b;
    if (sel == 0) begin
      d = if1.Data_Out; v = if1.Data_Valid; p = if1.Parity_Err;
      f = if1.Frame_Err; o = if1.Overrun; b = if1.RBusy;
    end else begin
      d = if16.Data_Out; v = if16.Data_Valid; p = if16.Parity_Err;
      f = if16.Frame_Err; o = if16.Overrun; b = if16.RBusy;
    end
    checkOutput({tag, ".data"},  32'(d), 32'(eData));
    checkOutput({tag, ".valid"}, 32'(v), 32'(eValid));
    checkOutput({tag, ".perr"},  32'(p), 32'(ePerr));
    checkOutput({tag, ".ferr"},  32'(f), 32'(eFerr));
    checkOutput({tag, ".ovr"},   32'(o), 32'(eOvr));
    checkOutput({tag, ".busy"},  32'(b), 32'(eBusy));
  endtask

  task automatic setLine(input int sel, input logic v);
    if (sel == 0) rx1 = v;
    else          rx16 = v;
  endtask

  task automatic setRead(input int sel, input logic v);
    if (sel == 0) if1.Data_Read = v;
    else          if16.Data_Read = v;
  endtask

  // Holds the serial line at a level for n cycles
  task automatic idleCycles(input int sel, input int n, input logic v);
    repeat (n) begin
      @(negedge Clk);
      setLine(sel, v);
    end
  endtask

  // Drives start, 8 data bits LSB first and the parity bit (optionally inverted)
  task automatic applyStimulus(input int sel, input logic [7:0] d, input logic parFlip);
    int cpb;
    logic [9:0] bits;
    cpb  = (sel == 0) ? 1 : 16;
    bits = {(^d) ^ parFlip, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      repeat (cpb) begin
        @(negedge Clk);
        setLine(sel, bits[b]);
      end
    end
  endtask

  // One-cycle Data_Read pulse, then valid and overrun must be clear
  task automatic readPulse(input int sel, input string tag);
    @(negedge Clk);
    setRead(sel, 1'b1);
    @(negedge Clk);
    setRead(sel, 1'b0);
    if (sel == 0) begin
      checkOutput({tag, ".rd_valid"}, 32'(if1.Data_Valid), 32'd0);
      checkOutput({tag, ".rd_ovr"},   32'(if1.Overrun),    32'd0);
    end else begin
      checkOutput({tag, ".rd_valid"}, 32'(if16.Data_Valid), 32'd0);
      checkOutput({tag, ".rd_ovr"},   32'(if16.Overrun),    32'd0);
    end
  endtask

  // Directed scenarios; after a 10-bit stimulus, commit lands H+3+SYNC_LAT cycles on
  initial begin
    if1.Data_Read  = 1'b0;
    if16.Data_Read = 1'b0;

    repeat (3) @(negedge Clk);
    checkState(0, "reset1",  8'h00, 0, 0, 0, 0, 0);
    checkState(1, "reset16", 8'h00, 0, 0, 0, 0, 0);
    Rst = 1'b1;
    idleCycles(0, 4, 1'b1);

    // Loopback-speed frame 0xA5, parity correct
    applyStimulus(0, 8'hA5, 1'b0);
    idleCycles(0, 2 + SYNC_LAT, 1'b1);
    checkState(0, "t1_pre", 8'h00, 0, 0, 0, 0, 1);
    idleCycles(0, 1, 1'b1);
    checkState(0, "t1", 8'hA5, 1, 0, 0, 0, 0);
    readPulse(0, "t1");
    checkState(0, "t1_held", 8'hA5, 0, 0, 0, 0, 0);

    // 16x oversampled frame 0x3C with inverted parity
    applyStimulus(1, 8'h3C, 1'b1);
    idleCycles(1, 9 + SYNC_LAT, 1'b1);
    checkState(1, "t2_pre", 8'h00, 0, 0, 0, 0, 1);
    idleCycles(1, 1, 1'b1);
    checkState(1, "t2", 8'h3C, 1, 1, 0, 0, 0);
    readPulse(1, "t2");

    // Three-cycle glitch: false start, busy for 8 cycles, nothing committed
    idleCycles(1, 3, 1'b0);
    idleCycles(1, 1, 1'b1);
    checkState(1, "t3_busy", 8'h3C, 0, 1, 0, 0, 1);
    idleCycles(1, 5 + SYNC_LAT, 1'b1);
    checkState(1, "t3_last", 8'h3C, 0, 1, 0, 0, 1);
    idleCycles(1, 1, 1'b1);
    checkState(1, "t3_drop", 8'h3C, 0, 1, 0, 0, 0);
    idleCycles(1, 200, 1'b1);
    checkState(1, "t3_quiet", 8'h3C, 0, 1, 0, 0, 0);

    // Overrun: two frames without a read
    applyStimulus(0, 8'h12, 1'b0);
    idleCycles(0, 3 + SYNC_LAT, 1'b1);
    checkState(0, "t4_first", 8'h12, 1, 0, 0, 0, 0);
    applyStimulus(0, 8'h34, 1'b0);
    idleCycles(0, 3 + SYNC_LAT, 1'b1);
    checkState(0, "t4_ovr", 8'h34, 1, 0, 0, 1, 0);
    readPulse(0, "t4");
    checkState(0, "t4_read", 8'h34, 0, 0, 0, 0, 0);

    // Read in the same cycle as a commit: new byte stays valid, no overrun
    applyStimulus(0, 8'h56, 1'b0);
    idleCycles(0, 3 + SYNC_LAT, 1'b1);
    checkState(0, "t4_56", 8'h56, 1, 0, 0, 0, 0);
    applyStimulus(0, 8'h78, 1'b0);
    idleCycles(0, 2 + SYNC_LAT, 1'b1);
    setRead(0, 1'b1);
    idleCycles(0, 1, 1'b1);
    setRead(0, 1'b0);
    checkState(0, "t4_simul", 8'h78, 1, 0, 0, 0, 0);
    readPulse(0, "t4_simul");

    // Low stop bit then a 30-bit break: one errored commit, then silence
    applyStimulus(1, 8'h55, 1'b0);
    idleCycles(1, 10 + SYNC_LAT, 1'b0);
    checkState(1, "t5_commit", 8'h55, 1, 0, 1, 0, 0);
    readPulse(1, "t5");
    idleCycles(1, 30 * 16, 1'b0);
    checkState(1, "t5_break", 8'h55, 0, 0, 1, 0, 0);
    idleCycles(1, 20, 1'b1);
    applyStimulus(1, 8'h81, 1'b0);
    idleCycles(1, 10 + SYNC_LAT, 1'b1);
    checkState(1, "t5_after", 8'h81, 1, 0, 0, 0, 0);

    // Reset in the middle of data bit 5 of 0xFF, then a clean 0x0F
    idleCycles(1, 16, 1'b0);
    idleCycles(1, 5 * 16 + 8, 1'b1);
    #2 Rst = 1'b0;
    #1;
    checkState(1, "t6_rst16", 8'h00, 0, 0, 0, 0, 0);
    checkState(0, "t6_rst1",  8'h00, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    idleCycles(1, 20, 1'b1);
    applyStimulus(1, 8'h0F, 1'b0);
    idleCycles(1, 10 + SYNC_LAT, 1'b1);
    checkState(1, "t6_after", 8'h0F, 1, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
